// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle 32x32 multiply / divide unit with architectural
// HI/LO registers. Multiplication is iterative shift-add, division is
// restoring shift-subtract; both work on magnitudes and apply the result sign
// in a final FIXUP cycle. Divide-by-zero short-circuits straight to DONE.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic             WriteHi,
    input  logic             WriteLo,
    input  logic [WIDTH-1:0] HiLoData,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    // Op encoding: bit 1 selects divide, bit 0 selects unsigned.
    localparam logic [1:0] OP_MULT = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_CALC  = 2'b01,
        S_FIXUP = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t               r_state;
    logic [1:0]           r_op;
    logic [WIDTH-1:0]     r_mag_a;     // |multiplicand| or |dividend|
    logic [WIDTH-1:0]     r_mag_b;     // |multiplier|  or |divisor|
    logic                 r_neg_res;   // product / quotient must be negated
    logic                 r_neg_rem;   // remainder must be negated (dividend < 0)
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_acc;       // product, or quotient in the low half
    logic [WIDTH-1:0]     r_rem;       // divide partial remainder (settled value)
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_dbz;

    // Start-time operand conditioning
    logic                 w_op_div;
    logic                 w_op_signed;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic                 w_neg_res;
    logic                 w_neg_rem;
    logic                 w_div_zero;

    // One iteration of each algorithm
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_shifted;   // 33-bit partial remainder before trial subtract
    logic                 w_sub_ok;
    logic [WIDTH-1:0]     w_rem_next;
    logic [WIDTH-1:0]     w_quo_next;

    // Sign fixup
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_fix_hi;
    logic [WIDTH-1:0]     w_fix_lo;

    // Operand magnitudes and result signs taken when a new operation starts
    always_comb begin
        w_op_div    = Op[1];
        w_op_signed = ~Op[0];
        w_abs_a     = (w_op_signed && OperandA[WIDTH-1]) ? -OperandA : OperandA;
        w_abs_b     = (w_op_signed && OperandB[WIDTH-1]) ? -OperandB : OperandB;
        w_neg_res   = w_op_signed & (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
        w_neg_rem   = w_op_signed & w_op_div & OperandA[WIDTH-1];
        w_div_zero  = w_op_div && (OperandB == '0);
    end

    // Single shift-add / restoring shift-subtract step
    always_comb begin
        // Multiply: conditionally add multiplicand to the upper half, then
        // shift the 65-bit {carry, acc} right by one.
        w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                     (r_acc[0] ? {1'b0, r_mag_a} : '0);
        w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

        // Divide: bring the next dividend bit into the partial remainder.
        // The 33rd bit keeps a 2^31 magnitude from overflowing the compare.
        w_shifted  = {r_rem, r_acc[WIDTH-1]};
        w_sub_ok   = (w_shifted >= {1'b0, r_mag_b});
        // When the subtract succeeds the result is < divisor, so the low
        // WIDTH bits of the difference are exact.
        w_rem_next = w_sub_ok ? (w_shifted[WIDTH-1:0] - r_mag_b) : w_shifted[WIDTH-1:0];
        w_quo_next = {r_acc[WIDTH-2:0], w_sub_ok};
    end

    // Signed result correction applied in FIXUP
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_fix_hi = '0;
        w_fix_lo = '0;
        w_prod   = r_neg_res ? -r_acc : r_acc;
        w_quo    = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem    = r_neg_rem ? -r_rem : r_rem;
        if (r_op[1]) begin
            w_fix_hi = w_rem;
            w_fix_lo = w_quo;
        end else begin
            w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod[WIDTH-1:0];
        end
    end

    // Control FSM with datapath registers and registered outputs
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (!Reset_n) begin
            r_state   <= S_IDLE;
            r_op      <= OP_MULT;
            r_mag_a   <= '0;
            r_mag_b   <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // mthi/mtlo land first; a divide-by-zero start at the same
                    // edge overrides them below.
                    if (WriteHi) r_hi <= HiLoData;
                    if (WriteLo) r_lo <= HiLoData;
                    if (Start) begin
                        r_op      <= Op;
                        r_mag_a   <= w_abs_a;
                        r_mag_b   <= w_abs_b;
                        r_neg_res <= w_neg_res;
                        r_neg_rem <= w_neg_rem;
                        r_cnt     <= '0;
                        r_rem     <= '0;
                        // Divide seeds the quotient shifter with the dividend,
                        // multiply seeds the low half with the multiplier.
                        r_acc     <= {{WIDTH{1'b0}}, (w_op_div ? w_abs_a : w_abs_b)};
                        r_busy    <= 1'b1;
                        if (w_div_zero) begin
                            r_hi    <= OperandA;
                            r_lo    <= '1;
                            r_done  <= 1'b1;
                            r_dbz   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_CALC;
                        end
                    end
                end

                S_CALC: begin
                    if (r_op[1]) begin
                        r_rem            <= w_rem_next;
                        r_acc[WIDTH-1:0] <= w_quo_next;
                    end else begin
                        r_acc <= w_mul_next;
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_FIXUP;
                    end
                end

                S_FIXUP: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end

                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Busy      = r_busy;
    assign Done      = r_done;
    assign DivByZero = r_dbz;
    assign Hi        = r_hi;
    assign Lo        = r_lo;

endmodule
